// File: rtl/bcim_ram_pkg.sv
// rtl/bcim_ram_pkg.sv - shared types for the dual-port bitline RAM and its requesters
package bcim_ram_pkg;

    localparam int RAM_ADDR_WIDTH = 8;
    localparam int RAM_DATA_WIDTH = 8;

    // Requester identity; also the encoding of the arbiter priority pointer
    typedef enum logic {
        REQ_HOST   = 1'b0,
        REQ_ENGINE = 1'b1
    } req_id_t;

    // One RAM access as seen on a port, sized to the RAM defaults
    typedef struct packed {
        logic                      we;
        logic [RAM_ADDR_WIDTH-1:0] addr;
        logic [RAM_DATA_WIDTH-1:0] wdata;
    } ram_req_t;

    // The requester that is not the given one
    function automatic req_id_t other_req(input req_id_t id);
        return (id == REQ_HOST) ? REQ_ENGINE : REQ_HOST;
    endfunction

endpackage

// File: rtl/bitline_port_arbiter.sv
// rtl/bitline_port_arbiter.sv - shares the dual-port bitline RAM between host loader and compute engine
module bitline_port_arbiter
    import bcim_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,

    input  logic                  req0_valid,
    input  logic                  req0_we,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [DATA_WIDTH-1:0] rsp0_rdata,

    input  logic                  req1_valid,
    input  logic                  req1_we,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [DATA_WIDTH-1:0] rsp1_rdata,

    output logic [ADDR_WIDTH-1:0] address_a,
    output logic [ADDR_WIDTH-1:0] address_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    output logic                  wren_a,
    output logic                  wren_b,
    input  logic [DATA_WIDTH-1:0] q_a,
    input  logic [DATA_WIDTH-1:0] q_b,

    output logic [CNT_WIDTH-1:0]  conflict_cnt
);

    req_id_t              r_prio;
    logic                 r_rsp0_valid;
    logic                 r_rsp1_valid;
    logic [CNT_WIDTH-1:0] r_conflict_cnt;

    logic w_conflict;
    logic w_ready0;
    logic w_ready1;
    logic w_grant0;
    logic w_grant1;

    // Same bitline touched by both with at least one write; two reads can share
    assign w_conflict = req0_valid && req1_valid && (req0_addr == req1_addr) &&
                        (req0_we || req1_we);

    // Ready is high unless reset or this requester lost the conflict to the pointer
    assign w_ready0 = !reset && !(w_conflict && (r_prio == REQ_ENGINE));
    assign w_ready1 = !reset && !(w_conflict && (r_prio == REQ_HOST));

    assign w_grant0 = req0_valid && w_ready0;
    assign w_grant1 = req1_valid && w_ready1;

    assign req0_ready = w_ready0;
    assign req1_ready = w_ready1;

    // Each requester owns its port; only the write enable is qualified by the grant
    assign address_a = req0_addr;
    assign data_a    = req0_wdata;
    assign wren_a    = w_grant0 && req0_we;
    assign address_b = req1_addr;
    assign data_b    = req1_wdata;
    assign wren_b    = w_grant1 && req1_we;

    // A response pending across a reset edge is dropped rather than delivered
    assign rsp0_valid = r_rsp0_valid && !reset;
    assign rsp1_valid = r_rsp1_valid && !reset;
    assign rsp0_rdata = q_a;
    assign rsp1_rdata = q_b;

    assign conflict_cnt = r_conflict_cnt;

    // Priority hand-off to the loser, read-response strobes and saturating conflict count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_prio         <= REQ_HOST;
            r_rsp0_valid   <= 1'b0;
            r_rsp1_valid   <= 1'b0;
            r_conflict_cnt <= '0;
        end else begin
            r_rsp0_valid <= w_grant0 && !req0_we;
            r_rsp1_valid <= w_grant1 && !req1_we;
            if (w_conflict) begin
                r_prio <= other_req(r_prio);
                if (r_conflict_cnt != {CNT_WIDTH{1'b1}}) begin
                    r_conflict_cnt <= r_conflict_cnt + 1'b1;
                end
            end
        end
    end

endmodule
